// File: rtl/mem_access_unit_if.sv
// Controller request/response and word-memory port bundle for mem_access_unit.
// slave = the access unit itself; master = the controller plus memory side.
interface mem_access_unit_if;
    logic        req;
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        done;
    logic        err;
    logic        busy;
    logic [31:0] mem_adr;
    logic        mem_we;
    logic [31:0] mem_wd;
    logic [31:0] mem_rd;

    modport slave (
        input  req, we, size, uns, addr, wdata, mem_rd,
        output rdata, done, err, busy, mem_adr, mem_we, mem_wd
    );

    modport master (
        output req, we, size, uns, addr, wdata, mem_rd,
        input  rdata, done, err, busy, mem_adr, mem_we, mem_wd
    );
endinterface

// File: rtl/mem_access_unit.sv
// Byte/half/word load-store sequencer onto a 1-cycle sync-read word memory (sub-word stores by RMW).
// done in cycle 1 (error) / 2 (sw) / 3 (load) / 4 (sb, sh); req is ignored while busy, no queuing.
module mem_access_unit #(
    parameter bit BIG_ENDIAN = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    mem_access_unit_if.slave bus
);
    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, WRITE, DONE} state_t;

    state_t      state;
    logic        we_q;
    logic        uns_q;
    logic [1:0]  size_q;
    logic [1:0]  off_q;
    logic [31:0] wdata_q;
    logic [31:0] rdata_q;
    logic [31:0] mem_adr_q;
    logic [31:0] mem_wd_q;
    logic        mem_we_q;
    logic        done_q;
    logic        err_q;

    logic        bad_req;
    logic [4:0]  shamt;
    logic [31:0] lane_mask;
    logic [31:0] lane;
    logic [31:0] ext_val;
    logic [31:0] merged;

    always_comb begin
        bad_req = (bus.size == 2'b11)
               || (bus.size == 2'b01 && bus.addr[0])
               || (bus.size == 2'b10 && bus.addr[1:0] != 2'b00);
    end

    // Lane position within the word: big-endian puts the lowest offset in the top bits.
    always_comb begin
        shamt     = 5'd0;
        lane_mask = 32'hFFFF_FFFF;
        case (size_q)
            2'b00: begin
                shamt     = BIG_ENDIAN ? {~off_q, 3'b000} : {off_q, 3'b000};
                lane_mask = 32'h0000_00FF;
            end
            2'b01: begin
                shamt     = BIG_ENDIAN ? {~off_q[1], 4'b0000} : {off_q[1], 4'b0000};
                lane_mask = 32'h0000_FFFF;
            end
            default: ;
        endcase
        lane    = (bus.mem_rd >> shamt) & lane_mask;
        ext_val = lane;
        if (!uns_q) begin
            if (size_q == 2'b00 && lane[7]) begin
                ext_val = lane | 32'hFFFF_FF00;
            end else if (size_q == 2'b01 && lane[15]) begin
                ext_val = lane | 32'hFFFF_0000;
            end
        end
        merged = (bus.mem_rd & ~(lane_mask << shamt)) | ((wdata_q & lane_mask) << shamt);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            we_q      <= 1'b0;
            uns_q     <= 1'b0;
            size_q    <= 2'b00;
            off_q     <= 2'b00;
            wdata_q   <= 32'd0;
            rdata_q   <= 32'd0;
            mem_adr_q <= 32'd0;
            mem_wd_q  <= 32'd0;
            mem_we_q  <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            done_q   <= 1'b0;
            mem_we_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.req) begin
                        we_q      <= bus.we;
                        uns_q     <= bus.uns;
                        size_q    <= bus.size;
                        off_q     <= bus.addr[1:0];
                        wdata_q   <= bus.wdata;
                        mem_adr_q <= {bus.addr[31:2], 2'b00};
                        if (bad_req) begin
                            err_q  <= 1'b1;
                            done_q <= 1'b1;
                            state  <= DONE;
                        end else begin
                            err_q <= 1'b0;
                            state <= ISSUE;
                            // Full-word stores need no read, so the write goes out with the address.
                            if (bus.we && bus.size == 2'b10) begin
                                mem_we_q <= 1'b1;
                                mem_wd_q <= bus.wdata;
                            end
                        end
                    end
                end
                ISSUE: begin
                    if (we_q && size_q == 2'b10) begin
                        done_q <= 1'b1;
                        state  <= DONE;
                    end else begin
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (!we_q) begin
                        rdata_q <= ext_val;
                        done_q  <= 1'b1;
                        state   <= DONE;
                    end else begin
                        mem_wd_q <= merged;
                        mem_we_q <= 1'b1;
                        state    <= WRITE;
                    end
                end
                WRITE: begin
                    done_q <= 1'b1;
                    state  <= DONE;
                end
                DONE: begin
                    err_q <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.rdata   = rdata_q;
    assign bus.done    = done_q;
    assign bus.err     = err_q;
    assign bus.busy    = (state != IDLE);
    assign bus.mem_adr = mem_adr_q;
    assign bus.mem_wd  = mem_wd_q;
    // Gated so a reset landing on the write edge leaves memory untouched.
    assign bus.mem_we  = mem_we_q & ~reset;
endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Load/store sequencer between the multicycle datapath/controller and the unified word-wide synchronous-read memory. Accepts one byte/halfword/word load or store per request, converts it into the memory's word-addressed, 1-cycle-latency protocol, and implements sub-word stores by read-modify-write. Returns extended load data plus a done/err pulse to the controller.

## Interface
- BIG_ENDIAN, 1: byte lane order. 1 = offset 0 in bits 31:24. 0 = offset 0 in bits 7:0.
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- req  in  1  request strobe; sampled only in IDLE
- we  in  1  1 = store, 0 = load
- size  in  2  00 byte, 01 half, 10 word, 11 reserved
- uns  in  1  loads only: 1 = zero-extend, 0 = sign-extend
- addr  in  32  byte address
- wdata  in  32  store data, right-aligned in bits [7:0] / [15:0] / [31:0]
- rdata  out  32  extended load result
- done  out  1  one-cycle completion pulse
- err  out  1  valid with done: misaligned or reserved size
- busy  out  1  state != IDLE
- mem_adr  out  32  memory address, always {addr[31:2],2'b00} of the latched request
- mem_we  out  1  memory write enable
- mem_wd  out  32  memory write data
- mem_rd  in  32  memory read data, registered by the memory one edge after mem_adr

## Operation
- States: IDLE, ISSUE, WAIT, WRITE, DONE.
- IDLE: if req=1 at an edge, latch we/size/uns/addr/wdata.
  - Misaligned request (half with addr[0]=1, word with addr[1:0]!=0) or size=11: go to DONE with err=1. No memory write occurs and rdata is unchanged.
  - Otherwise go to ISSUE.
- ISSUE: mem_adr is valid.
  - Word store: mem_we=1 and mem_wd=wdata; go to DONE.
  - Any other request: go to WAIT.
- WAIT: mem_rd holds the addressed word.
  - Load: extract the lane selected by addr[1:0] and size, extend it per uns, register the result into rdata; go to DONE.
  - Sub-word store: merge wdata[7:0] or wdata[15:0] into the selected lane of mem_rd, register the merged word into mem_wd; go to WRITE.
- WRITE: mem_we=1 with the merged word; go to DONE.
- DONE: done=1 and err is valid; go to IDLE.
- Lane mapping, BIG_ENDIAN=1:
  - byte offsets 0/1/2/3 map to bits [31:24]/[23:16]/[15:8]/[7:0]
  - half offsets 0/2 map to bits [31:16]/[15:0]
  - BIG_ENDIAN=0 mirrors this mapping.
- req is ignored in every state except IDLE; no queuing.
- rdata holds its value until the next successful load completes; stores do not change it.
- mem_we is gated by reset, so no memory write takes effect on an edge where reset=1.
- Address bits pass through unchecked. Wrap-around and out-of-range handling belong to the memory.

## Timing
- Reset values: state IDLE, rdata 0, done 0, err 0, busy 0, mem_adr 0, mem_we 0, mem_wd 0.
- Counting the cycle after the accepting edge E0 as cycle 1, done is high in:
  - cycle 2 for a word store
  - cycle 3 for any load
  - cycle 4 for a sub-word store
  - cycle 1 for an error
- Minimum spacing between accepts is latency + 1 cycles, because the DONE cycle is not accepting.
- Exactly one mem_we cycle per successful store; zero for loads and errors.
- Reset asserted in any state: next state IDLE and all outputs at reset values after that edge. An in-flight RMW is abandoned with memory unmodified.

## Test plan
- Preload word 0x10 = 0x11223344. Issue lw 0x10 → done in cycle 3, rdata=0x11223344, err=0, mem_we never 1.
- Preload word 0x20 = 0x80F0A5C3.
  - lb 0x20 → rdata 0xFFFFFF80
  - lbu 0x20 → 0x00000080
  - lh 0x22 → 0xFFFFA5C3
  - lhu 0x22 → 0x0000A5C3
- Issue sb wdata=0x000000AB at 0x11 on word 0x11223344 → one mem_we pulse in cycle 3 with mem_wd=0x11AB3344, done in cycle 4. A following lw 0x10 returns 0x11AB3344.
- Error cases:
  - lw 0x22 → done and err in cycle 1, no mem_we, rdata unchanged.
  - size=11 gives the same response.
  - sh 0x13 gives the same response.
- Hold req high continuously through a load → a second accept occurs only after the DONE cycle; busy is high from cycle 1 through the DONE cycle.
- Issue sh 0xBEEF at 0x20, then assert reset during the WRITE cycle → no memory write, word 0x20 stays 0x80F0A5C3, all outputs at reset values after the edge.
